// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared state encoding, opcodes, datapath select encodings and
//               the control-word structure for the multi-cycle MIPS control.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // Controller states; 12..14 are deliberately unused and trap to HALT
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_HALT   = 4'd15
  } state_e;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete control word driven into the datapath
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Combinational state -> control-word decode. Moore outputs
//               except irwrite/pc_en, which follow mem_ready / zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  // Per-state control word; everything defaults to 0 (HALT and unused codes)
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pc_en    = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMM_SH;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsource = PCSRC_ALUOUT;
        ctrl.pc_en    = zero;
      end
      ST_JUMP: begin
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.pc_en    = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main sequencing FSM for a multi-cycle MIPS datapath with a
//               shared instruction/data memory; tracks cycles and retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (dec_ctrl)
  );

  // Reset forces every strobe low so an interrupted access is abandoned at once
  always_comb begin
    ctrl = dec_ctrl;
    if (reset) ctrl = '0;
  end

  assign pc_en    = ctrl.pc_en;
  assign iord     = ctrl.iord;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsource = ctrl.pcsource;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign cycle    = cycle_q;
  assign instret  = instret_q;

  // Next-state, sticky illegal flag and retirement detection
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI: begin
            if (ENABLE_ADDI) begin
              state_d = ST_ADDIEX;
            end else begin
              state_d   = ST_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only sw goes to the write path; anything else completes as a load
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      default: begin
        state_d   = ST_HALT;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Free-running counters; cycle freezes in HALT, both wrap silently
  always_comb begin
    cycle_d   = (state_q != ST_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. An instruction-
//               level path model predicts state, control word and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int F = 0, D = 1, MA = 2, MRD = 3, MWB = 4, MWR = 5, EX = 6,
                 AWB = 7, BR = 8, JP = 9, AEX = 10, AIWB = 11, HLT = 15;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0]  opcode = 6'd0;

  logic        pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] cycle, instret;

  logic        pc_en4, iord4, memread4, memwrite4, irwrite4, memtoreg4, regdst4, regwrite4, alusrca4;
  logic [1:0]  alusrcb4, aluop4, pcsource4;
  logic [3:0]  state4;
  logic        illegal4;
  logic [3:0]  cycle4, instret4;

  multicycle_control #(.CNT_W(32), .ENABLE_ADDI(1'b1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .state(state),
    .illegal(illegal), .cycle(cycle), .instret(instret)
  );

  // Narrow-counter build shares the stimulus so counter wrap is observed
  multicycle_control #(.CNT_W(4), .ENABLE_ADDI(1'b1)) dut4 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en4), .iord(iord4), .memread(memread4), .memwrite(memwrite4), .irwrite(irwrite4),
    .memtoreg(memtoreg4), .regdst(regdst4), .regwrite(regwrite4), .alusrca(alusrca4),
    .alusrcb(alusrcb4), .aluop(aluop4), .pcsource(pcsource4), .state(state4),
    .illegal(illegal4), .cycle(cycle4), .instret(instret4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the state path of the instruction in flight
  int          m_path[$];
  int          m_idx;
  logic        m_valid = 1'b0;
  logic        m_illegal;
  logic [31:0] m_cycle, m_instret;
  logic [5:0]  cur_op;
  logic [5:0]  legal_ops[6];

  function automatic int m_state();
    return m_path[m_idx];
  endfunction

  // {pc_en,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsource}
  function automatic logic [14:0] exp_ctrl(int st, logic mr, logic z);
    logic pe, io, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pe, io, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      F:        begin mrd = 1; asb = 2'b01; irw = mr; pe = mr; end
      D:        asb = 2'b11;
      MA, AEX:  begin asa = 1; asb = 2'b10; end
      MRD:      begin mrd = 1; io = 1; end
      MWB:      begin rw = 1; m2r = 1; end
      MWR:      begin mwr = 1; io = 1; end
      EX:       begin asa = 1; aop = 2'b10; end
      AWB:      begin rw = 1; rd = 1; end
      BR:       begin asa = 1; aop = 2'b01; psrc = 2'b01; pe = z; end
      JP:       begin psrc = 2'b10; pe = 1; end
      AIWB:     rw = 1;
      default:  ;
    endcase
    return {pe, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock given the inputs that were sampled
  task automatic m_update(input logic rst, input logic [5:0] op, input logic mr);
    int  st;
    bit  hold;
    if (rst) begin
      m_path = '{F, D}; m_idx = 0;
      m_cycle = 0; m_instret = 0; m_illegal = 0; m_valid = 1;
      return;
    end
    st = m_state();
    if (st != HLT) m_cycle = m_cycle + 1;
    if (st == D) begin
      case (op)
        LW, SW: m_path.push_back(MA);
        RT:     begin m_path.push_back(EX); m_path.push_back(AWB); end
        BEQ:    m_path.push_back(BR);
        JMP:    m_path.push_back(JP);
        ADDI:   begin m_path.push_back(AEX); m_path.push_back(AIWB); end
        default: begin m_path.push_back(HLT); m_illegal = 1; end
      endcase
    end else if (st == MA) begin
      if (op == SW) m_path.push_back(MWR);
      else begin m_path.push_back(MRD); m_path.push_back(MWB); end
    end
    hold = (st == HLT) || (!mr && (st == F || st == MRD || st == MWR));
    if (!hold) begin
      if (m_idx == m_path.size() - 1) begin
        m_instret = m_instret + 1;
        m_path = '{F, D}; m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  // One clock: drive at negedge, check mid-low phase, update model at posedge
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr, input logic z);
    @(negedge clock);
    reset = rst; opcode = op; mem_ready = mr; zero = z;
    #1;
    if (rst) begin
      check("ctrl_in_reset", 32'({pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst,
                                  regwrite, alusrca, alusrcb, aluop, pcsource}), 32'd0);
    end
    if (m_valid) begin
      if (!rst)
        check("ctrl", 32'({pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
                           alusrca, alusrcb, aluop, pcsource}), 32'(exp_ctrl(m_state(), mr, z)));
      check("state",   32'(state),   32'(m_state()));
      check("illegal", 32'(illegal), 32'(m_illegal));
      check("cycle",   cycle,        m_cycle);
      check("instret", instret,      m_instret);
      check("cycle_w4", 32'(cycle4), 32'(m_cycle[3:0]));
    end
    @(posedge clock);
    m_update(rst, op, mr);
  endtask

  initial begin
    legal_ops[0] = RT; legal_ops[1] = LW; legal_ops[2] = SW;
    legal_ops[3] = BEQ; legal_ops[4] = JMP; legal_ops[5] = ADDI;

    // Reset for two clocks
    cyc(1, 6'd0, 0, 0);
    cyc(1, 6'd0, 0, 0);

    // lw with memory always ready
    repeat (5) cyc(0, LW, 1, 0);
    #1;
    check("lw_state_fetch", 32'(state), 32'd0);
    check("lw_instret", instret, 32'd1);
    check("lw_cycle", cycle, 32'd5);

    // sw with three wait cycles in MEMWR
    cyc(0, SW, 1, 0); cyc(0, SW, 1, 0); cyc(0, SW, 1, 0);
    repeat (3) cyc(0, 6'h3f, 0, 0);
    cyc(0, 6'h3f, 1, 0);
    #1;
    check("sw_instret", instret, 32'd2);

    // beq taken and not taken
    repeat (3) cyc(0, BEQ, 1, 1);
    repeat (3) cyc(0, BEQ, 1, 0);

    // R-type followed by jump
    repeat (4) cyc(0, RT, 1, 0);
    repeat (3) cyc(0, JMP, 1, 0);
    #1;
    check("rj_instret", instret, 32'd6);

    // Counter wrap on the narrow build: 20 clocks of lw after reset
    cyc(1, 6'd0, 1, 0);
    repeat (20) cyc(0, LW, 1, 0);
    #1;
    check("wrap_cycle4", 32'(cycle4), 32'd4);
    check("wrap_instret", instret, 32'd4);

    // Randomized legal traffic with random wait states and noisy opcode
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      int st;
      st = m_state();
      if (st == D) begin
        cur_op = legal_ops[$urandom_range(0, 5)];
        op = cur_op;
      end else if (st == MA) begin
        op = cur_op;
      end else begin
        op = 6'($urandom);
      end
      cyc(0, op, ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Illegal opcode: halt, sticky flag, frozen cycle count
    cyc(1, 6'd0, 1, 0);
    cyc(0, 6'h3f, 1, 0);
    cyc(0, 6'h3f, 1, 0);
    repeat (3) cyc(0, LW, 1, 1);
    #1;
    check("halt_state", 32'(state), 32'd15);
    check("halt_illegal", 32'(illegal), 32'd1);
    check("halt_cycle", cycle, 32'd2);
    cyc(1, 6'd0, 1, 0);
    #1;
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_illegal", 32'(illegal), 32'd0);

    // Reset in MEMRD while memory stalls
    cyc(0, LW, 1, 0); cyc(0, LW, 1, 0); cyc(0, LW, 1, 0);
    cyc(0, LW, 0, 0);
    cyc(1, LW, 0, 0);
    cyc(0, LW, 1, 0);

    // Reset in MEMWR while memory stalls: write strobe must drop
    cyc(0, SW, 1, 0); cyc(0, SW, 1, 0);
    cyc(0, SW, 0, 0);
    cyc(1, SW, 0, 0);
    cyc(0, RT, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_multicycle_control
`default_nettype wire
